// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch block: FSM encoding, widths and queue entry layout.
package fetch_pkg;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] PC_INC    = 32'd4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] pc);
      return pc & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO carrying {pc, instr}; flush empties it in one cycle and wins over push/pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          push_i,
   input  fetch_entry_t  push_data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic [CW-1:0] count_o,
   output fetch_entry_t  head_o
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_s, full_s, pop_s, push_s;

   // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      empty_s  = (count_q == '0);
      full_s   = (count_q == CW'(DEPTH));
      pop_s    = pop_i & ~empty_s;
      push_s   = push_i & (~full_s | pop_s);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         count_d = count_q + CW'(push_s) - CW'(pop_s);
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents of empty slots never reach the output.
   always_ff @(posedge clk_i) begin
      if (push_s && !flush_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = empty_s ? '0 : mem_q[rd_ptr_q];

   fetch_queue_chk u_chk (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (push_i),
      .flush_i (flush_i),
      .full_i  (full_s)
   );

endmodule

// File: rtl/fetch_queue_chk.sv
// Simulation checker for fetch_queue: the upstream issue rule must never overflow the queue.
module fetch_queue_chk (
   input logic clk_i,
   input logic rstn_i,
   input logic push_i,
   input logic flush_i,
   input logic full_i
);

   property p_no_overflow;
      @(posedge clk_i) disable iff (!rstn_i) !(push_i && full_i && !flush_i);
   endproperty

   a_no_overflow: assert property (p_no_overflow)
      else $error("fetch_queue: push into full queue");

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues reads to a 1-cycle-latency instruction memory, buffers into fetch_queue.
// Optional macro FETCH_PERF_CNT_EN adds saturating accept/stall counters o_FetchCnt/o_StallCnt.
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        i_Clk,
   input  logic        i_Rstn,
   output logic        o_MemReadEn,
   output logic [31:0] o_MemReadAddr,
   input  logic [31:0] i_MemReadData,
   input  logic        i_Redirect,
   input  logic [31:0] i_RedirectPc,
   output logic        o_InstrValid,
   output logic [31:0] o_Instr,
   output logic [31:0] o_InstrPc,
   input  logic        i_InstrReady
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] o_FetchCnt,
   output logic [31:0] o_StallCnt
`endif
);

   localparam int CW = $clog2(QDEPTH + 1);

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   pend_pc_q, pend_pc_d;
   logic          inflight_q, inflight_d;
   logic [CW-1:0] count_s;
   logic [CW:0]   occ_s, cap_s;
   fetch_entry_t  head_s, push_data_s;
   logic          valid_s, pop_s, push_s, kill_s, issue_s, fetch_en_s;

   // Handshake and issue decision: only issue when the returning word is guaranteed a slot.
   always_comb begin
      valid_s           = (count_s != '0);
      pop_s             = valid_s & i_InstrReady;
      kill_s            = i_Redirect;
      push_s            = inflight_q & ~kill_s;
      occ_s             = {1'b0, count_s} + {{CW{1'b0}}, inflight_q};
      cap_s             = (CW + 1)'(QDEPTH) + {{CW{1'b0}}, pop_s};
      fetch_en_s        = (state_q == RUN) || (state_q == FLUSH);
      issue_s           = fetch_en_s & ~i_Redirect & (occ_s < cap_s);
      push_data_s.pc    = pend_pc_q;
      push_data_s.instr = i_MemReadData;
   end

   // FSM, PC and pending-PC next-state; a redirect overrides everything else.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      inflight_d = issue_s;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = RUN;
         FLUSH:   state_d = RUN;
         default: state_d = BOOT;
      endcase
      if (i_Redirect) begin
         state_d = FLUSH;
         pc_d    = align_pc(i_RedirectPc);
      end else if (issue_s) begin
         pc_d      = pc_q + PC_INC;
         pend_pc_d = pc_q;
      end else begin
         pc_d = pc_q;
      end
   end

   // Controller state registers.
   always_ff @(posedge i_Clk) begin
      if (!i_Rstn) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         pend_pc_q  <= 32'h0000_0000;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pc_q  <= pend_pc_d;
         inflight_q <= inflight_d;
      end
   end

   fetch_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk_i       (i_Clk),
      .rstn_i      (i_Rstn),
      .push_i      (push_s),
      .push_data_i (push_data_s),
      .pop_i       (pop_s),
      .flush_i     (i_Redirect),
      .count_o     (count_s),
      .head_o      (head_s)
   );

   assign o_MemReadEn   = issue_s;
   assign o_MemReadAddr = pc_q;
   assign o_InstrValid  = valid_s;
   assign o_Instr       = head_s.instr;
   assign o_InstrPc     = head_s.pc;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating counters; redirects deliberately leave them untouched.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (pop_s && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end else begin
         fetch_cnt_d = fetch_cnt_q;
      end
      if (valid_s && !i_InstrReady && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge i_Clk) begin
      if (!i_Rstn) begin
         fetch_cnt_q <= 32'h0000_0000;
         stall_cnt_q <= 32'h0000_0000;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_FetchCnt = fetch_cnt_q;
   assign o_StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: streaming, back-pressure, redirects, PC wrap, reset, optional counters.
module tb_instr_fetch_ctrl;

   logic        i_Clk = 1'b0;
   logic        i_Rstn;
   logic        o_MemReadEn;
   logic [31:0] o_MemReadAddr;
   logic [31:0] i_MemReadData = 32'h0;
   logic        i_Redirect;
   logic [31:0] i_RedirectPc;
   logic        o_InstrValid;
   logic [31:0] o_Instr;
   logic [31:0] o_InstrPc;
   logic        i_InstrReady;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] o_FetchCnt;
   logic [31:0] o_StallCnt;
`endif

   int tests = 0;
   int fails = 0;

   instr_fetch_ctrl #(
      .RESET_PC (32'h0000_0000),
      .QDEPTH   (2)
   ) dut (
      .i_Clk         (i_Clk),
      .i_Rstn        (i_Rstn),
      .o_MemReadEn   (o_MemReadEn),
      .o_MemReadAddr (o_MemReadAddr),
      .i_MemReadData (i_MemReadData),
      .i_Redirect    (i_Redirect),
      .i_RedirectPc  (i_RedirectPc),
      .o_InstrValid  (o_InstrValid),
      .o_Instr       (o_Instr),
      .o_InstrPc     (o_InstrPc),
      .i_InstrReady  (i_InstrReady)
`ifdef FETCH_PERF_CNT_EN
      ,
      .o_FetchCnt    (o_FetchCnt),
      .o_StallCnt    (o_StallCnt)
`endif
   );

   always #5 i_Clk = ~i_Clk;

   // Synchronous-read memory whose word is 0xA000_0000 | address.
   always @(posedge i_Clk) begin
      i_MemReadData <= o_MemReadEn ? (32'hA000_0000 | o_MemReadAddr) : 32'h0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic smp();
      @(negedge i_Clk);
   endtask

   initial begin
      i_Rstn       = 1'b0;
      i_Redirect   = 1'b0;
      i_RedirectPc = 32'h0;
      i_InstrReady = 1'b1;
      nxt(); nxt(); smp();
      chk("rst_en",    o_MemReadEn,   32'h0);
      chk("rst_addr",  o_MemReadAddr, 32'h0);
      chk("rst_valid", o_InstrValid,  32'h0);
      chk("rst_instr", o_Instr,       32'h0);
      chk("rst_pc",    o_InstrPc,     32'h0);

      nxt(); i_Rstn = 1'b1; smp();
      chk("boot_en", o_MemReadEn, 32'h0);
      nxt(); smp();
      chk("c1_en", o_MemReadEn, 32'h1);
      chk("c1_addr", o_MemReadAddr, 32'h0);
      chk("c1_valid", o_InstrValid, 32'h0);
      nxt(); smp();
      chk("c2_addr", o_MemReadAddr, 32'h4);
      chk("c2_valid", o_InstrValid, 32'h0);
      nxt(); smp();
      chk("c3_addr", o_MemReadAddr, 32'h8);
      chk("c3_valid", o_InstrValid, 32'h1);
      chk("c3_pc", o_InstrPc, 32'h0);
      chk("c3_instr", o_Instr, 32'hA000_0000);
      nxt(); smp();
      chk("c4_addr", o_MemReadAddr, 32'hC);
      chk("c4_pc", o_InstrPc, 32'h4);
      chk("c4_instr", o_Instr, 32'hA000_0004);
      nxt(); smp();
      chk("c5_addr", o_MemReadAddr, 32'h10);
      chk("c5_pc", o_InstrPc, 32'h8);

      // Back-pressure: five cycles with ready low.
      nxt(); i_InstrReady = 1'b0; smp();
      chk("bp0_en", o_MemReadEn, 32'h0);
      chk("bp0_pc", o_InstrPc, 32'hC);
      nxt(); smp();
      chk("bp1_en", o_MemReadEn, 32'h0);
      chk("bp1_instr", o_Instr, 32'hA000_000C);
      for (int k = 0; k < 3; k++) begin
         nxt(); smp();
         chk("bp_hold_pc", o_InstrPc, 32'hC);
         chk("bp_hold_en", o_MemReadEn, 32'h0);
         chk("bp_hold_valid", o_InstrValid, 32'h1);
      end
      nxt(); i_InstrReady = 1'b1; smp();
      chk("bp_rel_pc", o_InstrPc, 32'hC);
      chk("bp_rel_en", o_MemReadEn, 32'h1);
      chk("bp_rel_addr", o_MemReadAddr, 32'h14);
      nxt(); smp();
      chk("bp_r1_pc", o_InstrPc, 32'h10);
      chk("bp_r1_addr", o_MemReadAddr, 32'h18);
      nxt(); smp();
      chk("bp_r2_pc", o_InstrPc, 32'h14);
      chk("bp_r2_addr", o_MemReadAddr, 32'h1C);

      // Redirect with a word in the queue and a read in flight.
      nxt(); i_InstrReady = 1'b0; i_Redirect = 1'b1; i_RedirectPc = 32'h0000_0103; smp();
      chk("rd1_en", o_MemReadEn, 32'h0);
      chk("rd1_pc", o_InstrPc, 32'h18);
      nxt(); i_Redirect = 1'b0; i_InstrReady = 1'b1; smp();
      chk("rd1_flush_valid", o_InstrValid, 32'h0);
      chk("rd1_flush_en", o_MemReadEn, 32'h1);
      chk("rd1_flush_addr", o_MemReadAddr, 32'h100);
      nxt(); smp();
      chk("rd1_c2_valid", o_InstrValid, 32'h0);
      chk("rd1_c2_addr", o_MemReadAddr, 32'h104);
      nxt(); smp();
      chk("rd1_c3_valid", o_InstrValid, 32'h1);
      chk("rd1_c3_pc", o_InstrPc, 32'h100);
      chk("rd1_c3_instr", o_Instr, 32'hA000_0100);
      nxt(); smp();
      chk("rd1_c4_pc", o_InstrPc, 32'h104);

      // Redirect coinciding with a pop and a push.
      nxt(); i_Redirect = 1'b1; i_RedirectPc = 32'h0000_0200; smp();
      chk("rd2_pc", o_InstrPc, 32'h108);
      chk("rd2_en", o_MemReadEn, 32'h0);
      nxt(); i_Redirect = 1'b0; smp();
      chk("rd2_c1_valid", o_InstrValid, 32'h0);
      chk("rd2_c1_addr", o_MemReadAddr, 32'h200);
      nxt(); smp();
      chk("rd2_c2_valid", o_InstrValid, 32'h0);
      nxt(); smp();
      chk("rd2_c3_pc", o_InstrPc, 32'h200);
      chk("rd2_c3_instr", o_Instr, 32'hA000_0200);

      // PC wrap through 0xFFFF_FFFC; low redirect bits ignored.
      nxt(); i_Redirect = 1'b1; i_RedirectPc = 32'hFFFF_FFFA; smp();
      chk("wr_en", o_MemReadEn, 32'h0);
      nxt(); i_Redirect = 1'b0; smp();
      chk("wr_c1_addr", o_MemReadAddr, 32'hFFFF_FFF8);
      chk("wr_c1_valid", o_InstrValid, 32'h0);
      nxt(); smp();
      chk("wr_c2_addr", o_MemReadAddr, 32'hFFFF_FFFC);
      nxt(); smp();
      chk("wr_c3_pc", o_InstrPc, 32'hFFFF_FFF8);
      chk("wr_c3_instr", o_Instr, 32'hFFFF_FFF8);
      chk("wr_c3_addr", o_MemReadAddr, 32'h0);
      nxt(); smp();
      chk("wr_c4_pc", o_InstrPc, 32'hFFFF_FFFC);
      nxt(); smp();
      chk("wr_c5_pc", o_InstrPc, 32'h0);
      chk("wr_c5_instr", o_Instr, 32'hA000_0000);

      // Reset mid-operation.
      nxt(); i_Rstn = 1'b0;
      nxt(); smp();
      chk("mrst_en", o_MemReadEn, 32'h0);
      chk("mrst_valid", o_InstrValid, 32'h0);
      chk("mrst_instr", o_Instr, 32'h0);
      chk("mrst_pc", o_InstrPc, 32'h0);
      chk("mrst_addr", o_MemReadAddr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("mrst_fcnt", o_FetchCnt, 32'h0);
      chk("mrst_scnt", o_StallCnt, 32'h0);
`endif

      // Redirect during the BOOT cycle.
      nxt(); i_Rstn = 1'b1; i_Redirect = 1'b1; i_RedirectPc = 32'h0000_0040; smp();
      chk("brd_en", o_MemReadEn, 32'h0);
      chk("brd_valid", o_InstrValid, 32'h0);
      nxt(); i_Redirect = 1'b0; smp();
      chk("brd_c1_en", o_MemReadEn, 32'h1);
      chk("brd_c1_addr", o_MemReadAddr, 32'h40);
      nxt(); smp();
      chk("brd_c2_addr", o_MemReadAddr, 32'h44);
      chk("brd_c2_valid", o_InstrValid, 32'h0);
      nxt(); smp();
      chk("brd_c3_pc", o_InstrPc, 32'h40);
      for (int k = 1; k <= 6; k++) begin
         nxt(); smp();
         chk("stream_pc", o_InstrPc, 32'h40 + 32'(4 * k));
      end

      // Three stall cycles, then three more accepts.
      nxt(); i_InstrReady = 1'b0; smp();
      chk("st0_pc", o_InstrPc, 32'h5C);
      nxt(); smp();
      nxt(); smp();
      chk("st2_pc", o_InstrPc, 32'h5C);
      chk("st2_en", o_MemReadEn, 32'h0);
      nxt(); i_InstrReady = 1'b1; smp();
      chk("st_rel_pc", o_InstrPc, 32'h5C);
      nxt(); smp();
      chk("st_r1_pc", o_InstrPc, 32'h60);
      nxt(); smp();
      chk("st_r2_pc", o_InstrPc, 32'h64);
      nxt(); smp();
      chk("st_r3_pc", o_InstrPc, 32'h68);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fcnt", o_FetchCnt, 32'd10);
      chk("perf_scnt", o_StallCnt, 32'd3);
`endif
      nxt(); i_Rstn = 1'b0;
      nxt(); smp();
      chk("end_rst_valid", o_InstrValid, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("end_rst_fcnt", o_FetchCnt, 32'h0);
      chk("end_rst_scnt", o_StallCnt, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
